// File: rtl/addsub_pkg.sv
// addsub_pkg: shared definitions for the pipelined adder/subtractor.
//   MODE_ADD / MODE_SUB : encoding of the 'm' mode input
//   calc_ns(w, blk)     : number of pipeline stages (one CLA block per stage)
package addsub_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  function automatic int calc_ns(input int w, input int blk);
    return w / blk;
  endfunction

endpackage

// File: rtl/cla_blk.sv
// cla_blk: combinational BLK-bit carry-lookahead block.
//   a, b  : block operand bits (b already conditionally inverted for subtract)
//   cin   : carry into bit 0 of the block
//   sum   : block sum bits
//   cout  : carry out of the block MSB
//   cmsb  : carry into the block MSB (used for signed overflow)
module cla_blk #(
  parameter int BLK = 4
) (
  input  logic [BLK-1:0] a,
  input  logic [BLK-1:0] b,
  input  logic           cin,
  output logic [BLK-1:0] sum,
  output logic           cout,
  output logic           cmsb
);

  logic [BLK-1:0] p;
  logic [BLK-1:0] g;
  logic [BLK:0]   cy;
  logic           c_run;

  assign p = a ^ b;
  assign g = a & b;

  // Carry i+1 = G[i] | P[i]&G[i-1] | ... | P[i..0]&cin; the running form
  // below flattens to the lookahead sum-of-products in synthesis.
  always_comb begin
    c_run = cin;
    cy    = '0;
    cy[0] = cin;
    for (int i = 0; i < BLK; i++) begin
      c_run   = g[i] | (p[i] & c_run);
      cy[i+1] = c_run;
    end
  end

  assign sum  = p ^ cy[BLK-1:0];
  assign cout = cy[BLK];
  assign cmsb = cy[BLK-1];

endmodule

// File: rtl/addsub_pipe.sv
// addsub_pipe: elastic W-bit two's-complement adder/subtractor, one BLK-bit
// carry-lookahead block resolved per pipeline stage (NS = W/BLK stages).
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid/in_ready   : operand handshake (a, b, m; m=1 means a-b)
//   out_valid/out_ready : result handshake (s, c, v, z, n)
//   c : carry out of bit W-1 (subtract: 1 = no borrow)
//   v : signed overflow, z : s==0, n : s[W-1]
// Build option: define ADDSUB_SAT_EN to clamp s on signed overflow; c and v
// still describe the unclamped result, z and n follow the clamped s.
module addsub_pipe
  import addsub_pkg::*;
#(
  parameter int W   = 16,
  parameter int BLK = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         m,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] s,
  output logic         c,
  output logic         v,
  output logic         z,
  output logic         n
);

  localparam int NS = calc_ns(W, BLK);

  // Per-stage registers: skewed operands, partial sum, carry, sign of a
  logic [W-1:0]  a_p   [NS];
  logic [W-1:0]  b_p   [NS];
  logic [W-1:0]  sum_p [NS];
  logic [NS-1:0] cy_p;
  logic [NS-1:0] sa_p;
  logic [NS-1:0] vld_p;
  logic          v_p;
  logic          z_p;
  logic          n_p;

  // Per-stage combinational inputs and block results
  logic [W-1:0]   st_a  [NS];
  logic [W-1:0]   st_b  [NS];
  logic [W-1:0]   st_s  [NS];
  logic [W-1:0]   nsum  [NS];
  logic [BLK-1:0] blk_s [NS];
  logic [NS-1:0]  st_c;
  logic [NS-1:0]  st_sa;
  logic [NS-1:0]  st_v;
  logic [NS-1:0]  blk_co;
  logic [NS-1:0]  blk_cm;
  logic [NS-1:0]  adv;

  logic [W-1:0]   s_fin;
  logic           v_nxt;

  // A stage moves when the consumer takes a result or any stage at or
  // below it (towards the output) holds a bubble that can absorb the shift.
  always_comb begin
    adv = '0;
    for (int i = 0; i < NS; i++) begin
      adv[i] = out_ready || !(&(vld_p | NS'((1 << i) - 1)));
    end
  end

  assign in_ready = rst_n && adv[0];

  genvar k;
  generate
    for (k = 0; k < NS; k++) begin : g_stage
      localparam logic [W-1:0] MASK = W'({BLK{1'b1}}) << (k * BLK);

      if (k == 0) begin : g_first
        // Stage 0: subtract is a + ~b + 1
        assign st_a[k]  = a;
        assign st_b[k]  = b ^ {W{m}};
        assign st_c[k]  = (m == MODE_SUB);
        assign st_s[k]  = '0;
        assign st_sa[k] = a[W-1];
        assign st_v[k]  = in_valid && in_ready;
      end else begin : g_next
        assign st_a[k]  = a_p[k-1];
        assign st_b[k]  = b_p[k-1];
        assign st_c[k]  = cy_p[k-1];
        assign st_s[k]  = sum_p[k-1];
        assign st_sa[k] = sa_p[k-1];
        assign st_v[k]  = vld_p[k-1];
      end

      cla_blk #(.BLK(BLK)) u_cla (
        .a    (st_a[k][k*BLK +: BLK]),
        .b    (st_b[k][k*BLK +: BLK]),
        .cin  (st_c[k]),
        .sum  (blk_s[k]),
        .cout (blk_co[k]),
        .cmsb (blk_cm[k])
      );

      assign nsum[k] = (st_s[k] & ~MASK) | (W'(blk_s[k]) << (k * BLK));
    end
  endgenerate

  assign v_nxt = blk_co[NS-1] ^ blk_cm[NS-1];

`ifdef ADDSUB_SAT_EN
  function automatic logic [W-1:0] sat_clamp(input logic [W-1:0] x,
                                             input logic        ovf,
                                             input logic        sgn);
    if (!ovf) return x;
    return sgn ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
  endfunction

  assign s_fin = sat_clamp(nsum[NS-1], v_nxt, st_sa[NS-1]);
`else
  assign s_fin = nsum[NS-1];
`endif

  // Stage boundary: every stage register loads only when its stage advances
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NS; i++) begin
        a_p[i]   <= '0;
        b_p[i]   <= '0;
        sum_p[i] <= '0;
      end
      cy_p  <= '0;
      sa_p  <= '0;
      vld_p <= '0;
      v_p   <= 1'b0;
      z_p   <= 1'b0;
      n_p   <= 1'b0;
    end else begin
      for (int i = 0; i < NS; i++) begin
        if (adv[i]) begin
          vld_p[i] <= st_v[i];
          a_p[i]   <= st_a[i];
          b_p[i]   <= st_b[i];
          cy_p[i]  <= blk_co[i];
          sa_p[i]  <= st_sa[i];
          sum_p[i] <= (i == NS - 1) ? s_fin : nsum[i];
        end
      end
      if (adv[NS-1]) begin
        v_p <= v_nxt;
        z_p <= (s_fin == '0);
        n_p <= s_fin[W-1];
      end
    end
  end

  assign out_valid = vld_p[NS-1];
  assign s         = sum_p[NS-1];
  assign c         = cy_p[NS-1];
  assign v         = v_p;
  assign z         = z_p;
  assign n         = n_p;

endmodule
